// File: rtl/alu_dispatch.sv
// alu_dispatch: single-issue dispatcher for RV32I OP / OP-IMM instructions.
// Accepts one instruction over a valid/ready handshake, reads its operands from
// the register file, issues it to either the base ALU or the SUB/SRA unit,
// captures the selected unit's registered result and writes it back.
//
// Ports:
//   clock, reset_n            - system clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready - instruction handshake (ready only in IDLE)
//   rs1_addr/rs2_addr/rs1_data/rs2_data - combinational register-file read
//   alu_enable/alu_extra_enable/funct3/operand_1/operand_2 - unit issue
//   alu_result/alu_extra_result - unit results (valid one edge after enable)
//   wb_valid/wb_addr/wb_data  - register-file write-back
//   illegal                   - one-cycle pulse after an illegal accept
//   retired                   - count of completed instructions (wraps)
module alu_dispatch (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        alu_enable,
  output logic        alu_extra_enable,
  output logic [2:0]  funct3,
  output logic [31:0] operand_1,
  output logic [31:0] operand_2,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_extra_result,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WB} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_idx_q, rs1_idx_d;
  logic [4:0]  rs2_idx_q, rs2_idx_d;
  logic        use_extra_q, use_extra_d;
  logic        alu_en_q, alu_en_d;
  logic        extra_en_q, extra_en_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;

  // Decode of the live instruction; only meaningful while IDLE.
  logic [6:0]  dec_opc;
  logic [2:0]  dec_f3;
  logic [6:0]  dec_f7;
  logic        dec_is_op;
  logic        dec_is_imm;
  logic        dec_legal;
  logic        dec_extra;
  logic        dec_shift_imm;
  logic [31:0] dec_op2;

  always_comb begin
    dec_opc       = instr[6:0];
    dec_f3        = instr[14:12];
    dec_f7        = instr[31:25];
    dec_is_op     = (dec_opc == OPC_OP);
    dec_is_imm    = (dec_opc == OPC_OP_IMM);
    dec_shift_imm = dec_is_imm && ((dec_f3 == 3'b001) || (dec_f3 == 3'b101));
    dec_legal     = 1'b0;
    if (dec_is_op) begin
      dec_legal = (dec_f7 == F7_BASE) ||
                  ((dec_f7 == F7_ALT) && ((dec_f3 == 3'b000) || (dec_f3 == 3'b101)));
    end else if (dec_is_imm) begin
      case (dec_f3)
        3'b001:  dec_legal = (dec_f7 == F7_BASE);
        3'b101:  dec_legal = (dec_f7 == F7_BASE) || (dec_f7 == F7_ALT);
        default: dec_legal = 1'b1;
      endcase
    end
    // Only SUB, SRA and SRAI can carry funct7[5] once legality is established;
    // ADDI etc. with bit 30 set in the immediate must stay on the base ALU.
    dec_extra = dec_legal && dec_f7[5] && (dec_is_op || dec_shift_imm);
    if (dec_is_op)
      dec_op2 = rs2_data;
    else if (dec_shift_imm)
      dec_op2 = {27'd0, instr[24:20]};
    else
      dec_op2 = {{20{instr[31]}}, instr[31:20]};
  end

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    use_extra_d = use_extra_q;
    alu_en_d    = 1'b0;
    extra_en_d  = 1'b0;
    funct3_d    = funct3_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    wb_valid_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    illegal_d   = 1'b0;
    retired_d   = retired_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          rd_d      = instr[11:7];
          rs1_idx_d = instr[19:15];
          rs2_idx_d = instr[24:20];
          if (dec_legal) begin
            state_d     = ISSUE;
            use_extra_d = dec_extra;
            alu_en_d    = !dec_extra;
            extra_en_d  = dec_extra;
            funct3_d    = dec_f3;
            op1_d       = rs1_data;
            op2_d       = dec_op2;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        // The unselected unit floats; only the issued unit is sampled.
        wb_data_d  = use_extra_q ? alu_extra_result : alu_result;
        wb_addr_d  = rd_q;
        wb_valid_d = (rd_q != 5'd0);
        state_d    = WB;
      end
      WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      use_extra_q <= 1'b0;
      alu_en_q    <= 1'b0;
      extra_en_q  <= 1'b0;
      funct3_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      use_extra_q <= use_extra_d;
      alu_en_q    <= alu_en_d;
      extra_en_q  <= extra_en_d;
      funct3_q    <= funct3_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign instr_ready      = (state_q == IDLE);
  assign rs1_addr         = (state_q == IDLE) ? instr[19:15] : rs1_idx_q;
  assign rs2_addr         = (state_q == IDLE) ? instr[24:20] : rs2_idx_q;
  assign alu_enable       = alu_en_q;
  assign alu_extra_enable = extra_en_q;
  assign funct3           = funct3_q;
  assign operand_1        = op1_q;
  assign operand_2        = op2_q;
  assign wb_valid         = wb_valid_q;
  assign wb_addr          = wb_addr_q;
  assign wb_data          = wb_data_q;
  assign illegal          = illegal_q;
  assign retired          = retired_q;

endmodule
